// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared LDPC controller types and code-table lookups
package ldpc_pkg;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_DEC = 2'd2, ST_OUT = 2'd3} state_t;
    typedef enum logic [1:0] {RATE_1_2 = 2'd0, RATE_2_3 = 2'd1, RATE_3_4 = 2'd2, RATE_5_6 = 2'd3} rate_t;
    typedef enum logic [1:0] {Z27 = 2'd0, Z54 = 2'd1, Z81 = 2'd2, Z_RSVD = 2'd3} zlen_t;

    localparam logic [4:0] NCOL_LAST = 5'd23;

    function automatic logic [3:0] nlyr_of(input logic [1:0] rate);
        case (rate)
            RATE_1_2: return 4'd12;
            RATE_2_3: return 4'd8;
            RATE_3_4: return 4'd6;
            default:  return 4'd4;
        endcase
    endfunction

    function automatic logic [4:0] ncol_msg_of(input logic [1:0] rate);
        case (rate)
            RATE_1_2: return 5'd12;
            RATE_2_3: return 5'd16;
            RATE_3_4: return 5'd18;
            default:  return 5'd20;
        endcase
    endfunction

    // The reserved length code decodes as Z81.
    function automatic logic [1:0] cvmax_of(input logic [1:0] zlen);
        return (zlen == Z_RSVD) ? 2'd2 : zlen;
    endfunction

endpackage

// File: rtl/ldpcdec_cu_if.sv
// rtl/ldpcdec_cu_if.sv - LLR input beat stream between source and decoder controller
interface ldpcdec_cu_if #(
    parameter int LLRW   = 6,
    parameter int ITER_W = 5
) ();
    logic                  vld_in;
    logic                  sop_in;
    logic [3:0]            mode_in;
    logic [ITER_W-1:0]     max_iter_in;
    logic [27*LLRW-1:0]    data_in;
    logic                  rdy_in;

    modport master (output vld_in, sop_in, mode_in, max_iter_in, data_in, input rdy_in);
    modport slave  (input vld_in, sop_in, mode_in, max_iter_in, data_in, output rdy_in);
endinterface

// File: rtl/ldpcdec_addr_cnt.sv
// rtl/ldpcdec_addr_cnt.sv - column/sub-block counter with cvmax wrap and terminal-count flag
module ldpcdec_addr_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       srst,
    input  logic       inc,
    input  logic [1:0] cvmax,
    input  logic [4:0] col_last,
    output logic [4:0] col,
    output logic [1:0] sub,
    output logic       last
);
    assign last = (col == col_last) && (sub == cvmax);

    // Wrapping to zero on the terminal count leaves the counter ready for the next packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            sub <= '0;
        end else if (srst) begin
            col <= '0;
            sub <= '0;
        end else if (inc) begin
            if (last) begin
                col <= '0;
                sub <= '0;
            end else if (sub == cvmax) begin
                col <= col + 5'd1;
                sub <= '0;
            end else begin
                sub <= sub + 2'd1;
            end
        end
    end
endmodule

// File: rtl/ldpcdec_cu.sv
// rtl/ldpcdec_cu.sv - LDPC decoder controller: LLR load, layered decode with early exit, hard-bit readout
module ldpcdec_cu
    import ldpc_pkg::*;
#(
    parameter int LLRW   = 6,
    parameter int ITER_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                srst,
    ldpcdec_cu_if.slave         in_if,
    input  logic                lyr_done,
    input  logic                synd_ok,
    output logic [1:0]          state,
    output logic [3:0]          mode,
    output logic                wr_en,
    output logic [6:0]          wr_addr,
    output logic [27*LLRW-1:0]  wr_data,
    output logic                lyr_start,
    output logic [3:0]          lyr_idx,
    output logic [ITER_W-1:0]   iter_cnt,
    output logic                rd_en,
    output logic [6:0]          rd_addr,
    output logic                vld_out,
    output logic                sop_out,
    output logic                eop_out,
    output logic                dec_ok
);
    state_t            state_q, state_d;
    logic [1:0]        cvmax_q, w_cvmax;
    logic [3:0]        nlyr_q;
    logic [4:0]        ncol_q;
    logic [ITER_W-1:0] max_iter_q;
    logic              dec_first, busy;
    logic              accept, sop_acc, ld_beat, done_acc, last_lyr, dec_exit, issue;
    logic [4:0]        wcol, rcol;
    logic [1:0]        wsub, rsub;
    logic              wlast, rlast;

    assign in_if.rdy_in = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept   = in_if.vld_in & in_if.rdy_in;
    assign sop_acc  = accept & in_if.sop_in & (state_q == ST_IDLE);
    assign ld_beat  = sop_acc | (accept & (state_q == ST_LOAD));
    // The sop beat is counted before cvmax_q is latched, so take its geometry from the input.
    assign w_cvmax  = (state_q == ST_IDLE) ? cvmax_of(in_if.mode_in[3:2]) : cvmax_q;
    assign done_acc = lyr_done & busy & (state_q == ST_DEC);
    assign last_lyr = (lyr_idx == nlyr_q - 4'd1);
    assign dec_exit = done_acc & last_lyr &
                      (synd_ok | (({1'b0, iter_cnt} + {{ITER_W{1'b0}}, 1'b1}) == {1'b0, max_iter_q}));
    assign issue    = dec_first | (done_acc & ~dec_exit);
    assign rd_en    = (state_q == ST_OUT);
    assign rd_addr  = {rcol, rsub};
    assign state    = state_q;

    ldpcdec_addr_cnt u_wr_cnt (
        .clk(clk), .rst_n(rst_n), .srst(srst), .inc(ld_beat), .cvmax(w_cvmax),
        .col_last(NCOL_LAST), .col(wcol), .sub(wsub), .last(wlast)
    );

    ldpcdec_addr_cnt u_rd_cnt (
        .clk(clk), .rst_n(rst_n), .srst(srst), .inc(rd_en), .cvmax(cvmax_q),
        .col_last(ncol_q - 5'd1), .col(rcol), .sub(rsub), .last(rlast)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sop_acc)          state_d = ST_LOAD;
            ST_LOAD: if (accept && wlast)  state_d = ST_DEC;
            ST_DEC:  if (dec_exit)         state_d = ST_OUT;
            ST_OUT:  if (rlast)            state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE; mode <= '0; cvmax_q <= '0; nlyr_q <= '0; ncol_q <= '0;
            max_iter_q <= '0; wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0; dec_first <= 1'b0;
            busy <= 1'b0; lyr_start <= 1'b0; lyr_idx <= '0; iter_cnt <= '0; dec_ok <= 1'b0;
            vld_out <= 1'b0; sop_out <= 1'b0; eop_out <= 1'b0;
        end else if (srst) begin
            state_q <= ST_IDLE; mode <= '0; cvmax_q <= '0; nlyr_q <= '0; ncol_q <= '0;
            max_iter_q <= '0; wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0; dec_first <= 1'b0;
            busy <= 1'b0; lyr_start <= 1'b0; lyr_idx <= '0; iter_cnt <= '0; dec_ok <= 1'b0;
            vld_out <= 1'b0; sop_out <= 1'b0; eop_out <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en   <= ld_beat;
            if (ld_beat) begin
                wr_addr <= {wcol, wsub};
                wr_data <= in_if.data_in;
            end
            if (sop_acc) begin
                mode       <= in_if.mode_in;
                cvmax_q    <= cvmax_of(in_if.mode_in[3:2]);
                nlyr_q     <= nlyr_of(in_if.mode_in[1:0]);
                ncol_q     <= ncol_msg_of(in_if.mode_in[1:0]);
                max_iter_q <= (in_if.max_iter_in == '0) ? ITER_W'(1) : in_if.max_iter_in;
                lyr_idx    <= '0;
                iter_cnt   <= '0;
            end
            // Layer issue is delayed one cycle past DEC entry so the last LLR write lands first.
            dec_first <= (state_q == ST_LOAD) && (state_d == ST_DEC);
            lyr_start <= issue;
            if (issue)         busy <= 1'b1;
            else if (done_acc) busy <= 1'b0;
            if (done_acc) begin
                if (last_lyr) begin
                    lyr_idx <= '0;
                    if (iter_cnt != '1) iter_cnt <= iter_cnt + ITER_W'(1);
                end else begin
                    lyr_idx <= lyr_idx + 4'd1;
                end
            end
            if (dec_exit) dec_ok <= synd_ok;
            vld_out <= rd_en;
            sop_out <= rd_en & (rcol == 5'd0) & (rsub == 2'd0);
            eop_out <= rd_en & rlast;
        end
    end
endmodule

// File: tb/tb_ldpcdec_cu.sv
// tb/tb_ldpcdec_cu.sv - randomized self-checking bench for ldpcdec_cu against a packet-level model
module tb_ldpcdec_cu;
    localparam int LLRW = 6, ITER_W = 5, DW = 27*LLRW;

    logic clk = 1'b0, rst_n = 1'b0, srst = 1'b0, lyr_done = 1'b0, synd_ok = 1'b0;
    logic [1:0] state; logic [3:0] mode; logic wr_en; logic [6:0] wr_addr; logic [DW-1:0] wr_data;
    logic lyr_start; logic [3:0] lyr_idx; logic [ITER_W-1:0] iter_cnt; logic rd_en; logic [6:0] rd_addr;
    logic vld_out, sop_out, eop_out, dec_ok;

    always #5 clk = ~clk;

    ldpcdec_cu_if #(.LLRW(LLRW), .ITER_W(ITER_W)) in_if ();

    ldpcdec_cu #(.LLRW(LLRW), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst_n(rst_n), .srst(srst), .in_if(in_if), .lyr_done(lyr_done), .synd_ok(synd_ok),
        .state(state), .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lyr_start(lyr_start), .lyr_idx(lyr_idx), .iter_cnt(iter_cnt), .rd_en(rd_en), .rd_addr(rd_addr),
        .vld_out(vld_out), .sop_out(sop_out), .eop_out(eop_out), .dec_ok(dec_ok)
    );

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Code tables written straight from the mode definitions
    function automatic int f_cv(input logic [1:0] z);   return (z == 2'd3) ? 2 : int'(z); endfunction
    function automatic int f_nlyr(input logic [1:0] r);
        case (r) 2'd0: return 12; 2'd1: return 8; 2'd2: return 6; default: return 4; endcase
    endfunction
    function automatic int f_nmsg(input logic [1:0] r);
        case (r) 2'd0: return 12; 2'd1: return 16; 2'd2: return 18; default: return 20; endcase
    endfunction
    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    logic [6:0]    exp_wr[$], exp_rd[$];
    logic [DW-1:0] exp_wd[$];
    int n_wr = 0, n_start = 0, n_vld = 0, n_rd = 0;
    int m_nlyr = 12, m_synd_iter = 0, m_k = 0, m_nout = 0;
    logic prev_rd_en = 1'b0;

    // Monitor: write/read address order, output framing, ready vs state
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("rdy_vs_state", in_if.rdy_in, state < 2'd2);
            if (wr_en) begin
                n_wr++;
                if (exp_wr.size() > 0) check("wr_addr", wr_addr, exp_wr.pop_front());
                else                   check("wr_extra", wr_en, 0);
                if (exp_wd.size() > 0) check("wr_data", wr_data, exp_wd.pop_front());
            end
            if (lyr_start) n_start++;
            if (rd_en) begin
                n_rd++;
                if (exp_rd.size() > 0) check("rd_addr", rd_addr, exp_rd.pop_front());
                else                   check("rd_extra", rd_en, 0);
            end
            check("vld_out_lat", vld_out, prev_rd_en);
            if (vld_out) begin
                check("sop_out", sop_out, n_vld == 0);
                check("eop_out", eop_out, n_vld == m_nout - 1);
                n_vld++;
            end
            prev_rd_en = rd_en;
        end
    end

    // Datapath responder: finishes each started layer after 0..3 cycles; syndrome passes only at
    // the end of iteration m_synd_iter; spurious lyr_done while no layer is outstanding
    initial begin
        int pend;
        bit syn_p;
        pend = 0; syn_p = 1'b0;
        forever begin
            @(posedge clk); #1;
            lyr_done = 1'b0; synd_ok = 1'b0;
            if (srst || !rst_n) pend = 0;
            else if (pend > 0) begin
                pend--;
                if (pend == 0) begin lyr_done = 1'b1; synd_ok = syn_p; end
            end else if (lyr_start) begin
                m_k++;
                syn_p = (m_k % m_nlyr == 0) ? (m_k / m_nlyr == m_synd_iter) : 1'($urandom_range(0, 1));
                pend = $urandom_range(0, 3);
                if (pend == 0) begin lyr_done = 1'b1; synd_ok = syn_p; end
            end else if (state == 2'd2 && $urandom_range(0, 1) == 1) begin
                lyr_done = 1'b1; synd_ok = 1'($urandom_range(0, 1));
            end
        end
    end

    // gap: 0 none, 1 vld toggling, 2 random idle cycles; abort: srst once 3 layers have started
    task automatic send_pkt(input logic [3:0] md, input int mi, input int si, input int gap, input bit abort);
        int cv, nb, maxe, ex_it, snap, cyc;
        bit ok;
        logic [DW-1:0] d;
        cv = f_cv(md[3:2]); nb = 24*(cv+1);
        m_nlyr = f_nlyr(md[1:0]); m_synd_iter = si; m_k = 0; m_nout = f_nmsg(md[1:0])*(cv+1);
        n_wr = 0; n_start = 0; n_vld = 0; n_rd = 0;
        exp_wr.delete(); exp_rd.delete(); exp_wd.delete();
        for (int c = 0; c < 24; c++) for (int s = 0; s <= cv; s++) exp_wr.push_back({5'(c), 2'(s)});
        for (int c = 0; c < f_nmsg(md[1:0]); c++) for (int s = 0; s <= cv; s++) exp_rd.push_back({5'(c), 2'(s)});
        maxe = (mi == 0) ? 1 : mi;
        ok = (si != 0) && (si <= maxe);
        ex_it = ok ? si : maxe;

        @(posedge clk); #1;
        in_if.vld_in = 1'b0; in_if.sop_in = 1'b1; in_if.mode_in = ~md;
        @(posedge clk); #1;
        in_if.sop_in = 1'b0;
        check("idle_sop_novld", state, 0);

        for (int b = 0; b < nb; b++) begin
            if (gap == 1 && b > 0) begin
                in_if.vld_in = 1'b0; in_if.data_in = rnd_data();
                @(posedge clk); #1;
            end else if (gap == 2) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_if.vld_in = 1'b0; in_if.sop_in = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            d = rnd_data();
            in_if.vld_in = 1'b1;
            in_if.sop_in = (b == 0) || (b == 5);
            in_if.mode_in = (b == 0) ? md : 4'($urandom());
            in_if.max_iter_in = (b == 0) ? ITER_W'(mi) : ITER_W'($urandom());
            in_if.data_in = d;
            exp_wd.push_back(d);
            @(posedge clk); #1;
        end
        in_if.vld_in = 1'b0; in_if.sop_in = 1'b0;
        check("dec_entry_state", state, 2);
        check("lyr_start_lat1", lyr_start, 0);
        @(posedge clk); #1;
        check("lyr_start_lat2", lyr_start, 1);

        if (abort) begin
            for (cyc = 0; cyc < 2000 && n_start < 3; cyc++) @(posedge clk);
            check("abort_wait", n_start >= 3, 1);
            @(negedge clk); srst = 1'b1;
            @(negedge clk); srst = 1'b0;
            check("srst_state", state, 0);
            check("srst_rdy", in_if.rdy_in, 1);
            check("srst_iter", iter_cnt, 0);
            exp_wr.delete(); exp_rd.delete(); exp_wd.delete();
            snap = n_start;
            repeat (10) @(posedge clk);
            #1;
            check("srst_no_start", n_start, snap);
            check("srst_idle", state, 0);
            return;
        end

        for (cyc = 0; cyc < 20000 && !(n_vld == m_nout && state == 2'd0); cyc++) @(posedge clk);
        #1;
        check("pkt_done", (n_vld == m_nout) && (state == 2'd0), 1);
        check("n_writes", n_wr, nb);
        check("n_layers", n_start, ex_it*m_nlyr);
        check("iter_cnt", iter_cnt, ex_it);
        check("dec_ok", dec_ok, ok);
        check("n_reads", n_rd, m_nout);
        check("n_out", n_vld, m_nout);
        check("mode_latched", mode, md);
        check("lyr_idx_end", lyr_idx, 0);
    endtask

    initial begin
        in_if.vld_in = 1'b0; in_if.sop_in = 1'b0; in_if.mode_in = '0; in_if.max_iter_in = '0; in_if.data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_rdy", in_if.rdy_in, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_lyr_start", lyr_start, 0);
        check("rst_iter", iter_cnt, 0);
        check("rst_dec_ok", dec_ok, 0);
        check("rst_vld_out", vld_out, 0);

        send_pkt(4'b0000, 10, 1, 0, 1'b0);
        send_pkt(4'b1011, 3, 0, 0, 1'b0);
        send_pkt(4'b0101, 2, 2, 1, 1'b0);
        send_pkt(4'b0000, 10, 0, 2, 1'b1);
        send_pkt(4'b1100, 0, 0, 0, 1'b0);
        send_pkt(4'b0110, 5, 6, 2, 1'b0);
        for (int i = 0; i < 8; i++)
            send_pkt(4'($urandom()), $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 2), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
